// File: rtl/counter_bank_drain_pkg.sv
// counter_bank_pkg: shared types and default sizing for the counter bank drain.
// Holds the scan FSM state encoding and the streamed (address, count) pair.
package counter_bank_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } pair_t;

endpackage

// File: rtl/counter_bank_drain.sv
// counter_bank_drain: walks the counter memory and streams (addr, count) pairs.
// Define COUNTER_BANK_DRAIN_CLEAR_EN to zero each entry as it is consumed.
module counter_bank_drain
  import counter_bank_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  output logic              io_busy,
  output logic [ADDR_W-1:0] io_mem_raddr,
  input  logic [DATA_W-1:0] io_mem_rdata,
  output logic              io_mem_wen,
  output logic [ADDR_W-1:0] io_mem_waddr,
  output logic [DATA_W-1:0] io_mem_wdata,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ADDR_W-1:0] io_out_addr,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_last,
  output logic              io_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              hs;

  assign hs = (state == SEND) && out_valid && io_out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (io_start) state_nx = FETCH;
      FETCH:   state_nx = SEND;
      SEND:    if (hs) state_nx = out_last ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // Pair holding register: loaded in FETCH, frozen until handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io_start) begin
            idx  <= '0;
            busy <= 1'b1;
          end
        end
        FETCH: begin
          out_data  <= io_mem_rdata;
          out_addr  <= idx;
          out_valid <= 1'b1;
          out_last  <= (idx == LAST_IDX);
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io_mem_raddr = idx;
    io_mem_wen   = 1'b0;
    io_mem_waddr = '0;
    io_mem_wdata = '0;
`ifdef COUNTER_BANK_DRAIN_CLEAR_EN
    io_mem_wen   = hs && !reset;
    io_mem_waddr = out_addr;
`endif
  end

  assign io_busy      = busy;
  assign io_done      = done;
  assign io_out_valid = out_valid;
  assign io_out_addr  = out_addr;
  assign io_out_data  = out_data;
  assign io_out_last  = out_last;

endmodule
